// File: rtl/seq01101_detect_pkg.sv
// Shared state encoding and transition rule for the 0-1-1-0-1 serial pattern detector.
// Each state records how much of the pattern has been seen so far.
package seq01101_detect_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] S_0    = 3'd1;
  localparam logic [STATE_W-1:0] S_01   = 3'd2;
  localparam logic [STATE_W-1:0] S_011  = 3'd3;
  localparam logic [STATE_W-1:0] S_0110 = 3'd4;

  // Prefix-tracking transition. After a full match the trailing "01" is kept,
  // so overlapping patterns are still found. Unused encodings fall back to idle.
  function automatic logic [STATE_W-1:0] nextState(input logic [STATE_W-1:0] cur,
                                                   input logic              bitIn);
    case (cur)
      S_IDLE:  nextState = bitIn ? S_IDLE : S_0;
      S_0:     nextState = bitIn ? S_01   : S_0;
      S_01:    nextState = bitIn ? S_011  : S_0;
      S_011:   nextState = bitIn ? S_IDLE : S_0110;
      S_0110:  nextState = bitIn ? S_01   : S_0;
      default: nextState = S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/seq01101_detect_bit_strobe.sv
// Bit-period strobe: pulses tick in the last enabled cycle of every BIT_CYCLES-clock bit period.
// The phase counter freezes while en is low, so pauses stretch the period instead of dropping bits.
module bit_strobe #(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int BC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BIT_CYCLES - 1);

  logic [BC_W-1:0] r_bc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bc <= '0;
    end else if (en) begin
      if (r_bc == BC_LAST) begin
        r_bc <= '0;
      end else begin
        r_bc <= r_bc + BC_W'(1);
      end
    end
  end

  assign tick = en && (r_bc == BC_LAST);

endmodule

// File: rtl/seq01101_detect.sv
// Serial 0-1-1-0-1 detector: one-cycle match pulse per (overlapping) occurrence,
// with a saturating match counter and a sticky overflow flag.
module seq01101_detect
  import seq01101_detect_pkg::*;
#(
  parameter int BIT_CYCLES = 4,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               din,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat,
  output logic [STATE_W-1:0] state
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic                 w_tick;
  logic                 w_hit;
  logic                 w_illegal;
  logic [STATE_W-1:0]   r_state;
  logic                 r_match;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_sat;

  bit_strobe #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_strobe (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .tick(w_tick)
  );

  assign w_hit     = w_tick && din && (r_state == S_0110);
  assign w_illegal = (r_state > S_0110);

  // An illegal encoding recovers to idle on the next clock even without a tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else if (w_tick || w_illegal) begin
      r_state <= nextState(r_state, din);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_match <= 1'b0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_match <= w_hit;
      if (w_hit) begin
        if (r_cnt == CNT_MAX) begin
          r_sat <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign match     = r_match;
  assign match_cnt = r_cnt;
  assign cnt_sat   = r_sat;
  assign state     = r_state;

endmodule

// File: tb/tb_seq01101_detect.sv
// Bench for seq01101_detect: two instances (slow 4-clock bits with wide counter, per-cycle bits
// with a 2-bit counter) checked every cycle against a sampled-bit history model.
module tb_seq01101_detect;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       din;

  logic       matchA;
  logic [7:0] cntA;
  logic       satA;
  logic [2:0] stateA;

  logic       matchB;
  logic [1:0] cntB;
  logic       satB;
  logic [2:0] stateB;

  int vecCount  = 0;
  int missCount = 0;

  // Per-instance model: enabled-cycle count, last sampled bits, number of valid bits.
  int bcCfg[2]  = '{4, 1};
  int maxCfg[2] = '{255, 3};
  int mEcnt[2];
  int mHist[2];
  int mHlen[2];
  int mCnt[2];
  int mMatch[2];
  int mSat[2];

  always #5 clk = ~clk;

  seq01101_detect #(.BIT_CYCLES(4), .CNT_W(8)) dutA (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .match(matchA), .match_cnt(cntA), .cnt_sat(satA), .state(stateA)
  );

  seq01101_detect #(.BIT_CYCLES(1), .CNT_W(2)) dutB (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .match(matchB), .match_cnt(cntB), .cnt_sat(satB), .state(stateB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Expected prefix length = longest tail of the sampled bits that starts the pattern 01101.
  function automatic int modelState(input int i);
    for (int k = 4; k >= 1; k--) begin
      if (mHlen[i] >= k && (mHist[i] & ((1 << k) - 1)) == (13 >> (5 - k))) return k;
    end
    return 0;
  endfunction

  task automatic modelStep(input logic r, input logic e, input logic d);
    for (int i = 0; i < 2; i++) begin
      mMatch[i] = 0;
      if (r) begin
        mEcnt[i] = 0; mHist[i] = 0; mHlen[i] = 0; mCnt[i] = 0; mSat[i] = 0;
      end else if (e) begin
        if ((mEcnt[i] % bcCfg[i]) == bcCfg[i] - 1) begin
          mHist[i] = ((mHist[i] << 1) | int'(d)) & 31;
          if (mHlen[i] < 5) mHlen[i]++;
          if (mHlen[i] == 5 && mHist[i] == 13) begin
            mMatch[i] = 1;
            if (mCnt[i] == maxCfg[i]) mSat[i] = 1;
            else mCnt[i]++;
          end
        end
        mEcnt[i]++;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic d);
    rst = r; en = e; din = d;
    @(posedge clk);
    modelStep(r, e, d);
    #1;
    checkOutput("A.match", 32'(matchA), 32'(mMatch[0]));
    checkOutput("A.cnt",   32'(cntA),   32'(mCnt[0]));
    checkOutput("A.sat",   32'(satA),   32'(mSat[0]));
    checkOutput("A.state", 32'(stateA), 32'(modelState(0)));
    checkOutput("B.match", 32'(matchB), 32'(mMatch[1]));
    checkOutput("B.cnt",   32'(cntB),   32'(mCnt[1]));
    checkOutput("B.sat",   32'(satB),   32'(mSat[1]));
    checkOutput("B.state", 32'(stateB), 32'(modelState(1)));
  endtask

  task automatic sendBit(input logic d);
    repeat (4) applyStimulus(1'b0, 1'b1, d);
  endtask

  task automatic sendBits(input logic [15:0] bits, input int n);
    for (int j = n - 1; j >= 0; j--) sendBit(bits[j]);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; din = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mEcnt[i] = 0; mHist[i] = 0; mHlen[i] = 0; mCnt[i] = 0; mMatch[i] = 0; mSat[i] = 0;
    end
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0);

    sendBits(16'b01101, 5);
    checkOutput("basicCnt", 32'(cntA), 32'd1);
    checkOutput("basicState", 32'(stateA), 32'd2);

    applyStimulus(1'b1, 1'b1, 1'b0);
    sendBits(16'b01101101, 8);
    checkOutput("overlapCnt", 32'(cntA), 32'd2);

    applyStimulus(1'b1, 1'b1, 1'b0);
    sendBits(16'b0111011001, 10);
    checkOutput("nearMissCnt", 32'(cntA), 32'd0);
    checkOutput("nearMissState", 32'(stateA), 32'd2);

    applyStimulus(1'b1, 1'b1, 1'b0);
    sendBits(16'b0110, 4);
    applyStimulus(1'b1, 1'b1, 1'b1);
    sendBit(1'b1);
    checkOutput("rstMidCnt", 32'(cntA), 32'd0);
    checkOutput("rstMidState", 32'(stateA), 32'd0);

    // Pause in the middle of the third bit; din held while disabled.
    applyStimulus(1'b1, 1'b1, 1'b0);
    sendBits(16'b01, 2);
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b1);
    repeat (7) applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b1);
    sendBits(16'b01, 2);
    checkOutput("pauseCnt", 32'(cntA), 32'd1);

    // Per-cycle stream with five overlapping matches saturates instance B.
    applyStimulus(1'b1, 1'b1, 1'b0);
    begin
      logic [16:0] satStream;
      satStream = 17'b01101101101101101;
      for (int j = 16; j >= 0; j--) applyStimulus(1'b0, 1'b1, satStream[j]);
    end
    checkOutput("satCnt", 32'(cntB), 32'd3);
    checkOutput("satFlag", 32'(satB), 32'd1);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("satSticky", 32'(satB), 32'd1);

    for (int n = 0; n < 4000; n++) begin
      applyStimulus(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
                    1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
